// File: rtl/sdram_write_pkg.sv
// Shared definitions for the SDRAM write engine: SDRAM command encodings,
// the precharge-all address, write FSM states and a counter-width helper.
package sdram_write_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_PALL  = 4'b0010;
  localparam logic [3:0] CMD_AREF  = 4'b0001;

  localparam logic [12:0] PALL_ADDR = 13'h0400;

  typedef enum logic [4:0] {
    WR_IDLE   = 5'b00001,
    WR_REQ    = 5'b00010,
    WR_ACTIVE = 5'b00100,
    WR_WRITE  = 5'b01000,
    WR_PRE    = 5'b10000
  } wr_state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sdram_write_if.sv
// Arbiter, SDRAM command and wfifo signals of the write engine.
// With SDRAM_WR_STAT_EN defined the bus also carries wr_burst_total.
interface sdram_write_if #(
  parameter int unsigned FIFO_DW = 8
);
  logic               wr_trig;
  logic               wr_en;
  logic               aref_req;
  logic               wr_req;
  logic               flag_wr_end;
  logic [3:0]         wr_cmd;
  logic [12:0]        wr_addr;
  logic [15:0]        wr_data;
  logic               wfifo_rd_en;
  logic [FIFO_DW-1:0] wfifo_rd_data;
`ifdef SDRAM_WR_STAT_EN
  logic [15:0]        wr_burst_total;
`endif

  modport master (
    output wr_trig, wr_en, aref_req, wfifo_rd_data,
    input  wr_req, flag_wr_end, wr_cmd, wr_addr, wr_data, wfifo_rd_en
`ifdef SDRAM_WR_STAT_EN
    , input wr_burst_total
`endif
  );

  modport slave (
    input  wr_trig, wr_en, aref_req, wfifo_rd_data,
    output wr_req, flag_wr_end, wr_cmd, wr_addr, wr_data, wfifo_rd_en
`ifdef SDRAM_WR_STAT_EN
    , output wr_burst_total
`endif
  );

endinterface

// File: rtl/sdram_write_addr_cnt.sv
// Beat/column/row counters of the write engine with burst, row-end and
// data-end flags; *_nxt outputs give the values the next cycle will hold.
module sdram_wr_addr_cnt
  import sdram_write_pkg::*;
#(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned COL_END   = 3,
  parameter int unsigned ROW_END   = 1,
  localparam int unsigned BW = cnt_width(BURST_LEN),
  localparam int unsigned CW = 10 - BW,
  localparam int unsigned RW = cnt_width(ROW_END)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cnt_en,
  output logic [BW-1:0] burst_nxt,
  output logic [CW-1:0] col_nxt,
  output logic [RW-1:0] row_cnt,
  output logic          burst_last,
  output logic          row_end,
  output logic          data_end
);

  logic [BW-1:0] burst_cnt;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_nxt;

  always_comb begin
    burst_last = (burst_cnt == BW'(BURST_LEN - 1));
    row_end    = burst_last && (col_cnt == CW'(COL_END - 1));
    data_end   = row_end && (row_cnt == RW'(ROW_END - 1));
  end

  always_comb begin
    burst_nxt = burst_cnt;
    col_nxt   = col_cnt;
    row_nxt   = row_cnt;
    if (cnt_en) begin
      burst_nxt = burst_last ? '0 : burst_cnt + BW'(1);
      if (burst_last) col_nxt = row_end ? '0 : col_cnt + CW'(1);
      if (row_end)    row_nxt = data_end ? '0 : row_cnt + RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt <= '0;
      col_cnt   <= '0;
      row_cnt   <= '0;
    end else begin
      burst_cnt <= burst_nxt;
      col_cnt   <= col_nxt;
      row_cnt   <= row_nxt;
    end
  end

endmodule

// File: rtl/sdram_write.sv
// SDRAM burst-write engine: requests the bus, opens a row, streams wfifo
// bursts, precharges and yields to refresh. Option: SDRAM_WR_STAT_EN.
module sdram_write
  import sdram_write_pkg::*;
#(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned COL_END   = 3,
  parameter int unsigned ROW_END   = 1,
  parameter int unsigned FIFO_DW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  sdram_write_if.slave  bus
);

  localparam int unsigned BW = cnt_width(BURST_LEN);
  localparam int unsigned CW = 10 - BW;
  localparam int unsigned RW = cnt_width(ROW_END);

  wr_state_t     state, state_n;
  logic          busy;
  logic          cnt_en;
  logic [BW-1:0] burst_nxt;
  logic [CW-1:0] col_nxt;
  logic [RW-1:0] row_cnt;
  logic          burst_last, row_end, data_end;
  logic [3:0]    cmd_d;
  logic [12:0]   addr_d;
  logic          flag_d;

  assign cnt_en = (state == WR_WRITE);

  sdram_wr_addr_cnt #(
    .BURST_LEN (BURST_LEN),
    .COL_END   (COL_END),
    .ROW_END   (ROW_END)
  ) u_addr_cnt (
    .clk        (clk),
    .rst        (rst),
    .cnt_en     (cnt_en),
    .burst_nxt  (burst_nxt),
    .col_nxt    (col_nxt),
    .row_cnt    (row_cnt),
    .burst_last (burst_last),
    .row_end    (row_end),
    .data_end   (data_end)
  );

  // Command/address are registered from state_n so they line up with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= WR_IDLE;
      busy            <= 1'b0;
      bus.wr_cmd      <= CMD_NOP;
      bus.wr_addr     <= PALL_ADDR;
      bus.flag_wr_end <= 1'b0;
    end else begin
      state           <= state_n;
      bus.wr_cmd      <= cmd_d;
      bus.wr_addr     <= addr_d;
      bus.flag_wr_end <= flag_d;
      if (state == WR_IDLE && bus.wr_trig) busy <= 1'b1;
      else if (cnt_en && data_end)         busy <= 1'b0;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      WR_IDLE:   if (bus.wr_trig) state_n = WR_REQ;
      WR_REQ:    if (bus.wr_en)   state_n = WR_ACTIVE;
      WR_ACTIVE: state_n = WR_WRITE;
      // data_end implies row_end, so it needs no term of its own
      WR_WRITE:  if (burst_last && (bus.aref_req || row_end)) state_n = WR_PRE;
      WR_PRE: begin
        if (!busy)             state_n = WR_IDLE;
        else if (bus.aref_req) state_n = WR_REQ;
        else                   state_n = WR_ACTIVE;
      end
      default:   state_n = WR_IDLE;
    endcase
  end

  always_comb begin
    cmd_d  = CMD_NOP;
    addr_d = PALL_ADDR;
    unique case (state_n)
      WR_ACTIVE: begin
        cmd_d  = CMD_ACT;
        addr_d = 13'(row_cnt);
      end
      WR_WRITE: begin
        cmd_d  = (burst_nxt == '0) ? CMD_WRITE : CMD_NOP;
        addr_d = {3'b000, col_nxt, burst_nxt};
      end
      WR_PRE:  cmd_d = CMD_PALL;
      default: ;
    endcase
    flag_d = (state == WR_PRE) && (state_n != WR_ACTIVE);
  end

  assign bus.wr_req      = (state_n == WR_REQ);
  assign bus.wfifo_rd_en = (state_n == WR_WRITE);
  assign bus.wr_data     = 16'(bus.wfifo_rd_data[FIFO_DW-1:0]);

`ifdef SDRAM_WR_STAT_EN
  always_ff @(posedge clk) begin
    if (rst)
      bus.wr_burst_total <= '0;
    else if (cnt_en && burst_last && bus.wr_burst_total != '1)
      bus.wr_burst_total <= bus.wr_burst_total + 16'd1;
  end
`endif

endmodule

// File: tb/tb_sdram_write.sv
// Directed bench for sdram_write: default instance plus a ROW_END=2 instance
// for the row-change case; the wfifo is a 1-cycle-latency model.
module tb_sdram_write;

  localparam logic [3:0]  NOP  = 4'b0111;
  localparam logic [3:0]  ACT  = 4'b0011;
  localparam logic [3:0]  WR   = 4'b0100;
  localparam logic [3:0]  PALL = 4'b0010;
  localparam logic [12:0] A10  = 13'h0400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fifo_clr = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] fmem [0:31];
  int   fptr;

  always #5 clk = ~clk;

  sdram_write_if #(.FIFO_DW(8)) bus1 ();
  sdram_write_if #(.FIFO_DW(8)) bus2 ();

  sdram_write #(.BURST_LEN(4), .COL_END(3), .ROW_END(1), .FIFO_DW(8)) dut (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  sdram_write #(.BURST_LEN(4), .COL_END(3), .ROW_END(2), .FIFO_DW(8)) dut2 (
    .clk (clk), .rst (rst), .bus (bus2)
  );

  always @(posedge clk) begin
    if (fifo_clr) fptr <= 0;
    else if (bus1.wfifo_rd_en) begin
      bus1.wfifo_rd_data <= fmem[fptr];
      fptr <= fptr + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fifo();
    fifo_clr = 1'b1;
    step();
    fifo_clr = 1'b0;
  endtask

  // Trigger, grant after two REQ cycles; returns in the ACT cycle.
  task automatic start1();
    bus1.wr_trig = 1'b1;
    step();
    bus1.wr_trig = 1'b0;
    step();
    bus1.wr_en = 1'b1;
    step();
    bus1.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus1.wr_trig = 0; bus1.wr_en = 0; bus1.aref_req = 0; bus1.wfifo_rd_data = '0;
    bus2.wr_trig = 0; bus2.wr_en = 0; bus2.aref_req = 0; bus2.wfifo_rd_data = '0;
    step(); step();
    checks++; if (bus1.wr_cmd !== NOP) begin errors++; $display("FAIL reset_cmd got %b want %b", bus1.wr_cmd, NOP); end
    checks++; if (bus1.wr_addr !== A10) begin errors++; $display("FAIL reset_addr got %h want %h", bus1.wr_addr, A10); end
    checks++; if (bus1.wr_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", bus1.wr_req); end
    checks++; if (bus1.flag_wr_end !== 1'b0) begin errors++; $display("FAIL reset_flag got %b want 0", bus1.flag_wr_end); end
    checks++; if (bus1.wfifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", bus1.wfifo_rd_en); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_transfer();
    clear_fifo();
    bus1.wr_trig = 1'b1;
    #1;
    checks++; if (bus1.wr_req !== 1'b1) begin errors++; $display("FAIL xfer_req_comb got %b want 1", bus1.wr_req); end
    step();
    bus1.wr_trig = 1'b0;
    checks++; if (bus1.wr_cmd !== NOP || bus1.wr_req !== 1'b1) begin errors++; $display("FAIL xfer_req got cmd %b req %b want %b 1", bus1.wr_cmd, bus1.wr_req, NOP); end
    step();
    bus1.wr_en = 1'b1;
    #1;
    checks++; if (bus1.wr_req !== 1'b0) begin errors++; $display("FAIL xfer_req_drop got %b want 0", bus1.wr_req); end
    step();
    bus1.wr_en = 1'b0;
    checks++; if (bus1.wr_cmd !== ACT || bus1.wr_addr !== 13'd0) begin errors++; $display("FAIL xfer_act got %b/%h want %b/0", bus1.wr_cmd, bus1.wr_addr, ACT); end
    for (int i = 0; i < 12; i++) begin
      step();
      checks++; if (bus1.wr_cmd !== ((i % 4 == 0) ? WR : NOP)) begin errors++; $display("FAIL xfer_cmd beat %0d got %b", i, bus1.wr_cmd); end
      checks++; if (bus1.wr_addr !== 13'(i)) begin errors++; $display("FAIL xfer_addr beat %0d got %h want %h", i, bus1.wr_addr, 13'(i)); end
      checks++; if (bus1.wr_data !== {8'h00, fmem[i]}) begin errors++; $display("FAIL xfer_data beat %0d got %h want %h", i, bus1.wr_data, {8'h00, fmem[i]}); end
    end
    checks++; if (bus1.wfifo_rd_en !== 1'b0) begin errors++; $display("FAIL xfer_rd_en_last got %b want 0", bus1.wfifo_rd_en); end
    step();
    checks++; if (bus1.wr_cmd !== PALL || bus1.wr_addr !== A10 || bus1.flag_wr_end !== 1'b0) begin errors++; $display("FAIL xfer_pall got %b/%h flag %b", bus1.wr_cmd, bus1.wr_addr, bus1.flag_wr_end); end
    step();
    checks++; if (bus1.flag_wr_end !== 1'b1 || bus1.wr_cmd !== NOP || bus1.wr_req !== 1'b0) begin errors++; $display("FAIL xfer_flag got flag %b cmd %b req %b want 1 %b 0", bus1.flag_wr_end, bus1.wr_cmd, bus1.wr_req, NOP); end
    step();
    checks++; if (bus1.flag_wr_end !== 1'b0) begin errors++; $display("FAIL xfer_flag_width got %b want 0", bus1.flag_wr_end); end
    checks++; if (fptr !== 12) begin errors++; $display("FAIL xfer_pops got %0d want 12", fptr); end
  endtask

  task automatic test_refresh();
    clear_fifo();
    start1();
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (bus1.wr_addr !== 13'(i) || bus1.wr_cmd !== ((i % 4 == 0) ? WR : NOP)) begin errors++; $display("FAIL aref_beat %0d got %b/%h", i, bus1.wr_cmd, bus1.wr_addr); end
      if (i == 5) bus1.aref_req = 1'b1;
    end
    checks++; if (bus1.wfifo_rd_en !== 1'b0 || bus1.wr_req !== 1'b0) begin errors++; $display("FAIL aref_last got rd_en %b req %b want 0 0", bus1.wfifo_rd_en, bus1.wr_req); end
    step();
    checks++; if (bus1.wr_cmd !== PALL || bus1.wr_req !== 1'b1) begin errors++; $display("FAIL aref_pall got %b req %b want %b 1", bus1.wr_cmd, bus1.wr_req, PALL); end
    step();
    bus1.aref_req = 1'b0;
    checks++; if (bus1.flag_wr_end !== 1'b1 || bus1.wr_req !== 1'b1) begin errors++; $display("FAIL aref_flag got flag %b req %b want 1 1", bus1.flag_wr_end, bus1.wr_req); end
    step();
    checks++; if (bus1.flag_wr_end !== 1'b0 || bus1.wr_req !== 1'b1) begin errors++; $display("FAIL aref_wait got flag %b req %b want 0 1", bus1.flag_wr_end, bus1.wr_req); end
    bus1.wr_en = 1'b1;
    step();
    bus1.wr_en = 1'b0;
    checks++; if (bus1.wr_cmd !== ACT || bus1.wr_addr !== 13'd0) begin errors++; $display("FAIL aref_act got %b/%h want %b/0", bus1.wr_cmd, bus1.wr_addr, ACT); end
    for (int i = 8; i < 12; i++) begin
      step();
      checks++; if (bus1.wr_addr !== 13'(i) || bus1.wr_cmd !== ((i == 8) ? WR : NOP)) begin errors++; $display("FAIL aref_resume beat %0d got %b/%h", i, bus1.wr_cmd, bus1.wr_addr); end
      checks++; if (bus1.wr_data !== {8'h00, fmem[i]}) begin errors++; $display("FAIL aref_data beat %0d got %h want %h", i, bus1.wr_data, {8'h00, fmem[i]}); end
    end
    step();
    checks++; if (bus1.wr_cmd !== PALL) begin errors++; $display("FAIL aref_end_pall got %b want %b", bus1.wr_cmd, PALL); end
    step();
    checks++; if (bus1.flag_wr_end !== 1'b1) begin errors++; $display("FAIL aref_end_flag got %b want 1", bus1.flag_wr_end); end
    checks++; if (fptr !== 12) begin errors++; $display("FAIL aref_pops got %0d want 12", fptr); end
    step();
  endtask

  task automatic test_row_change();
    bus2.wr_trig = 1'b1;
    step();
    bus2.wr_trig = 1'b0;
    step();
    bus2.wr_en = 1'b1;
    step();
    bus2.wr_en = 1'b0;
    checks++; if (bus2.wr_cmd !== ACT || bus2.wr_addr !== 13'd0) begin errors++; $display("FAIL row_act0 got %b/%h want %b/0", bus2.wr_cmd, bus2.wr_addr, ACT); end
    for (int i = 0; i < 12; i++) step();
    checks++; if (bus2.wr_addr !== 13'd11) begin errors++; $display("FAIL row_last0 got %h want 00b", bus2.wr_addr); end
    step();
    checks++; if (bus2.wr_cmd !== PALL || bus2.wr_req !== 1'b0) begin errors++; $display("FAIL row_pall got %b req %b want %b 0", bus2.wr_cmd, bus2.wr_req, PALL); end
    step();
    checks++; if (bus2.wr_cmd !== ACT || bus2.wr_addr !== 13'd1) begin errors++; $display("FAIL row_act1 got %b/%h want %b/001", bus2.wr_cmd, bus2.wr_addr, ACT); end
    checks++; if (bus2.flag_wr_end !== 1'b0 || bus2.wr_req !== 1'b0) begin errors++; $display("FAIL row_noflag got flag %b req %b want 0 0", bus2.flag_wr_end, bus2.wr_req); end
    step();
    checks++; if (bus2.wr_cmd !== WR || bus2.wr_addr !== 13'd0) begin errors++; $display("FAIL row_write1 got %b/%h want %b/0", bus2.wr_cmd, bus2.wr_addr, WR); end
    for (int i = 1; i < 12; i++) step();
    step();
    checks++; if (bus2.wr_cmd !== PALL) begin errors++; $display("FAIL row_end_pall got %b want %b", bus2.wr_cmd, PALL); end
    step();
    checks++; if (bus2.flag_wr_end !== 1'b1) begin errors++; $display("FAIL row_end_flag got %b want 1", bus2.flag_wr_end); end
    step();
  endtask

  task automatic test_aref_data_end();
    int pulses;
    clear_fifo();
    start1();
    for (int i = 0; i < 12; i++) step();
    bus1.aref_req = 1'b1;
    pulses = 0;
    step();
    checks++; if (bus1.wr_cmd !== PALL || bus1.wr_req !== 1'b0) begin errors++; $display("FAIL both_pall got %b req %b want %b 0", bus1.wr_cmd, bus1.wr_req, PALL); end
    for (int i = 0; i < 5; i++) begin
      step();
      bus1.aref_req = 1'b0;
      if (bus1.flag_wr_end === 1'b1) pulses++;
      checks++; if (bus1.wr_req !== 1'b0 || bus1.wr_cmd !== NOP) begin errors++; $display("FAIL both_idle cycle %0d got req %b cmd %b want 0 %b", i, bus1.wr_req, bus1.wr_cmd, NOP); end
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL both_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_reset_mid();
    clear_fifo();
    start1();
    for (int i = 0; i < 3; i++) step();
    checks++; if (bus1.wr_addr !== 13'd2) begin errors++; $display("FAIL rstmid_beat2 got %h want 002", bus1.wr_addr); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus1.wr_cmd !== NOP || bus1.wr_addr !== A10) begin errors++; $display("FAIL rstmid_nop got %b/%h want %b/%h", bus1.wr_cmd, bus1.wr_addr, NOP, A10); end
    checks++; if (bus1.wr_req !== 1'b0 || bus1.wfifo_rd_en !== 1'b0 || bus1.flag_wr_end !== 1'b0) begin errors++; $display("FAIL rstmid_idle got req %b rd_en %b flag %b want 0 0 0", bus1.wr_req, bus1.wfifo_rd_en, bus1.flag_wr_end); end
    step();
    checks++; if (bus1.wr_cmd !== NOP) begin errors++; $display("FAIL rstmid_stay got %b want %b", bus1.wr_cmd, NOP); end
    clear_fifo();
    start1();
    checks++; if (bus1.wr_cmd !== ACT || bus1.wr_addr !== 13'd0) begin errors++; $display("FAIL rstmid_act got %b/%h want %b/0", bus1.wr_cmd, bus1.wr_addr, ACT); end
    step();
    checks++; if (bus1.wr_cmd !== WR || bus1.wr_addr !== 13'd0) begin errors++; $display("FAIL rstmid_write got %b/%h want %b/0", bus1.wr_cmd, bus1.wr_addr, WR); end
    for (int i = 0; i < 16; i++) step();
  endtask

  initial begin
    fmem[0] = 8'hA5; fmem[1] = 8'h5A; fmem[2] = 8'h3C; fmem[3] = 8'hC3;
    for (int i = 4; i < 32; i++) fmem[i] = 8'(8'h40 + i);
    test_reset();
    test_transfer();
    test_refresh();
    test_row_change();
    test_aref_data_end();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
